// File: rtl/conv3x3_stream.sv
// conv3x3_stream: raster-stream 3x3 convolution with two internal line buffers and a
// double-buffered signed kernel. Define CONV_ABS_OUT_EN for a |sum| edge-magnitude output.
module conv3x3_stream #(
  parameter int PIX_W   = 12,
  parameter int COORD_W = 11,
  parameter int IMG_W   = 1280,
  parameter int COEF_W  = 4,
  parameter int OUT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [PIX_W-1:0]         in_pixel,
  input  logic [COORD_W-1:0]       in_x,
  input  logic [COORD_W-1:0]       in_y,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [COORD_W-1:0]       out_x,
  output logic [COORD_W-1:0]       out_y
);

  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int SUM_W  = PIX_W + COEF_W + 5;
  localparam int AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  localparam coef_t SOBEL_X [9] = '{coef_t'(-1), coef_t'(0), coef_t'(1),
                                    coef_t'(-2), coef_t'(0), coef_t'(2),
                                    coef_t'(-1), coef_t'(0), coef_t'(1)};
  localparam sum_t SAT_HI  = sum_t'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam sum_t SAT_LO  = sum_t'(-(64'sd1 <<< (OUT_W - 1)));
  localparam sum_t PIX_MAX = sum_t'((64'sd1 <<< PIX_W) - 64'sd1);

  logic                accept, frame_start, emit;
  logic [AW-1:0]       lb_addr;
  logic                synced;
  coef_t               shadow [9];
  coef_t               active [9];

  logic                s0_valid, s0_emit;
  logic [PIX_W-1:0]    s0_pix, rd1, rd2;
  logic [COORD_W-1:0]  s0_x, s0_y, s1_x, s1_y, s2_x, s2_y;
  logic [PIX_W-1:0]    lb1 [IMG_W];
  logic [PIX_W-1:0]    lb2 [IMG_W];

  logic [PIX_W-1:0]    win [3][3];
  coef_t               k1 [9];
  logic                s1_valid, s2_valid;
  prod_t               prod [9];
  sum_t                sum;
  logic signed [OUT_W-1:0] sat;

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    accept      = in_valid && ({1'b0, in_x} < (COORD_W + 1)'(IMG_W));
    frame_start = accept && (in_x == '0) && (in_y == '0);
    emit        = accept && synced && (in_x >= COORD_W'(2)) && (in_y >= COORD_W'(2));
    lb_addr     = in_x[AW-1:0];
  end

  // Input capture; the kernel swap is tied to the frame-start pixel so it can never tear a frame.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_emit  <= 1'b0;
      s0_pix   <= '0;
      s0_x     <= '0;
      s0_y     <= '0;
      synced   <= 1'b0;
      active   <= SOBEL_X;
      shadow   <= SOBEL_X;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_emit <= emit;
        s0_pix  <= in_pixel;
        s0_x    <= in_x - COORD_W'(1);
        s0_y    <= in_y - COORD_W'(1);
      end
      if (frame_start) begin
        active <= shadow;
        synced <= 1'b1;
      end
      if (coef_we && (coef_addr <= 4'd8)) shadow[coef_addr] <= coef_wdata;
    end
  end

  // NOTE: line-buffer RAMs carry no reset; stale rows are flushed by the first two lines of a frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[lb_addr] <= in_pixel;
      lb2[lb_addr] <= lb1[lb_addr];
      rd1          <= lb1[lb_addr];
      rd2          <= lb2[lb_addr];
    end
  end

  // Stage 1: window shift; the kernel snapshot travels with the pixel so in-flight results keep theirs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      k1       <= SOBEL_X;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else begin
      s1_valid <= s0_valid && s0_emit;
      if (s0_valid) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= rd2;
        win[1][2] <= rd1;
        win[2][2] <= s0_pix;
        s1_x      <= s0_x;
        s1_y      <= s0_y;
        k1        <= active;
      end
    end
  end

  // Stage 2: nine exact products of zero-extended pixels and signed coefficients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
      for (int i = 0; i < 9; i++) prod[i] <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_x <= s1_x;
        s2_y <= s1_y;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            prod[r*3+c] <= prod_t'($signed({1'b0, win[r][c]})) * prod_t'(k1[r*3+c]);
      end
    end
  end

`ifdef CONV_ABS_OUT_EN
  sum_t mag;
`endif

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum += sum_t'(prod[i]);
`ifdef CONV_ABS_OUT_EN
    mag = sum[SUM_W-1] ? -sum : sum;
    sat = OUT_W'((mag > PIX_MAX) ? PIX_MAX : mag);
`else
    if (sum > SAT_HI)      sat = OUT_W'(SAT_HI);
    else if (sum < SAT_LO) sat = OUT_W'(SAT_LO);
    else                   sat = OUT_W'(sum);
`endif
  end

  // Stage 3: adder tree plus saturation, registered onto the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= sat;
        out_x    <= s2_x;
        out_y    <= s2_y;
      end
    end
  end

endmodule
